// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: sequential double-dabble BCD conversion feeding an 8-digit multiplexed seven-segment scan.
// Define SEVENSEG_LZ_BLANK_EN to blank leading-zero digits (digit 0 is always shown).
module sevenseg_scan_driver #(
    parameter int REFRESH_CYCLES = 100_000,
    parameter int REFRESH_WIDTH  = $clog2(REFRESH_CYCLES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] number,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        bcd_valid
);
    // REFRESH_CYCLES=1 gives a zero-width counter; keep at least one bit
    localparam int CW = REFRESH_WIDTH < 1 ? 1 : REFRESH_WIDTH;
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    state_t        state;
    logic [23:0]   bin;
    logic [31:0]   bcd, bcd_adj, display;
    logic [4:0]    iter;
    logic [CW-1:0] cnt;
    logic          wrap;
    logic [2:0]    idx;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    dec;

    for (genvar g = 0; g < 8; g++) begin : g_adj
        assign bcd_adj[4*g +: 4] = bcd[4*g +: 4] >= 4'd5 ? bcd[4*g +: 4] + 4'd3 : bcd[4*g +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bin       <= '0;
            bcd       <= '0;
            iter      <= '0;
            display   <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= state == COMMIT;
            case (state)
                IDLE: begin
                    bin   <= number;
                    bcd   <= '0;
                    iter  <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    iter       <= iter + 5'd1;
                    if (iter == 5'd23) state <= COMMIT;
                end
                default: begin
                    display <= bcd;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign wrap = cnt == CW'(REFRESH_CYCLES - 1);
    assign nib  = display[{idx, 2'b00} +: 4];
`ifdef SEVENSEG_LZ_BLANK_EN
    assign blank = idx != 3'd0 && (display >> {idx, 2'b00}) == '0;
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        dec = 7'h7F;
        case (nib)
            4'd0: dec = 7'b1000000;
            4'd1: dec = 7'b1111001;
            4'd2: dec = 7'b0100100;
            4'd3: dec = 7'b0110000;
            4'd4: dec = 7'b0011001;
            4'd5: dec = 7'b0010010;
            4'd6: dec = 7'b0000010;
            4'd7: dec = 7'b1111000;
            4'd8: dec = 7'b0000000;
            4'd9: dec = 7'b0010000;
            default: dec = 7'h7F;
        endcase
    end

    // an and seg come from the same idx on the same edge, so they never disagree
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            cnt <= wrap ? '0 : cnt + CW'(1);
            if (wrap) idx <= idx + 3'd1;
            an  <= ~(8'd1 << idx);
            seg <= blank ? 7'h7F : dec;
            dp  <= 1'b1;
        end
    end
endmodule
